// File: rtl/reg_file_mp.sv
// Multi-ported integer register file with optional write-to-read bypass and a
// per-register busy scoreboard for issue-time hazard detection.
module reg_file_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [NUM_WR-1:0]        reg_wr_en,
    input  logic [NUM_WR*AW-1:0]     write_reg,
    input  logic [NUM_WR*XLEN-1:0]   write_data,
    input  logic [NUM_RD*AW-1:0]     read_reg,
    output logic [NUM_RD*XLEN-1:0]   read_data,
    output logic [NUM_RD-1:0]        read_busy,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_reg,
    output logic [NREGS-1:0]         busy_vec
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_next;

    logic [AW-1:0]    wr_addr [NUM_WR];
    logic [XLEN-1:0]  wr_data [NUM_WR];
    logic [NUM_WR-1:0] wr_act;

    for (genvar k = 0; k < NUM_WR; k++) begin : g_wr_unpack
        assign wr_addr[k] = write_reg[k*AW +: AW];
        assign wr_data[k] = write_data[k*XLEN +: XLEN];
        assign wr_act[k]  = reg_wr_en[k] && (wr_addr[k] != '0);
    end

    // Clears are applied before the reservation so a same-cycle set wins.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        busy_next = busy_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_act[k]) busy_next[wr_addr[k]] = 1'b0;
        end
        if (rsv_en && (rsv_reg != '0)) busy_next[rsv_reg] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // NOTE: the storage array is reset here because software expects every
    // architectural register to read zero after reset; a datapath RAM would
    // normally be left unreset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            busy_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            // Ascending port order lets the higher-index port win a conflict.
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_act[k]) regs[wr_addr[k]] <= wr_data[k];
            end
            busy_q <= busy_next;
        end
    end

    assign busy_vec = busy_q;

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;

        assign ra = read_reg[j*AW +: AW];

        always_comb begin
            rd = regs[ra];
            if (BYPASS != 0) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_act[k] && (wr_addr[k] == ra)) rd = wr_data[k];
                end
            end
            // Bypass would otherwise leak write data while reset is held.
            if (!resetn || (ra == '0)) rd = '0;
        end

        assign read_data[j*XLEN +: XLEN] = rd;
        assign read_busy[j]              = busy_q[ra];
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed scoreboard bench for reg_file_mp: a bypassing 2-write-port instance
// and a non-bypassing 1-write-port instance share the same stimulus.
module tb_reg_file_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic               clock = 1'b0;
    logic               resetn;
    logic [1:0]         reg_wr_en;
    logic [2*AW-1:0]    write_reg;
    logic [2*XLEN-1:0]  write_data;
    logic [2*AW-1:0]    read_reg;
    logic               rsv_en;
    logic [AW-1:0]      rsv_reg;

    logic [2*XLEN-1:0]  rd_a, rd_b;
    logic [1:0]         rb_a, rb_b;
    logic [31:0]        vec_a, vec_b;

    reg_file_mp #(.XLEN(XLEN), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut_a (
        .clock(clock), .resetn(resetn), .reg_wr_en(reg_wr_en), .write_reg(write_reg),
        .write_data(write_data), .read_reg(read_reg), .read_data(rd_a), .read_busy(rb_a),
        .rsv_en(rsv_en), .rsv_reg(rsv_reg), .busy_vec(vec_a)
    );

    reg_file_mp #(.XLEN(XLEN), .NREGS(32), .NUM_RD(2), .NUM_WR(1), .BYPASS(0)) dut_b (
        .clock(clock), .resetn(resetn), .reg_wr_en(reg_wr_en[0:0]), .write_reg(write_reg[AW-1:0]),
        .write_data(write_data[XLEN-1:0]), .read_reg(read_reg), .read_data(rd_b), .read_busy(rb_b),
        .rsv_en(rsv_en), .rsv_reg(rsv_reg), .busy_vec(vec_b)
    );

    always #5 clock = ~clock;

    typedef enum int { K_DATA, K_BUSY, K_VEC } kind_t;
    typedef struct {
        string       name;
        int          dut;
        kind_t       kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] actual(exp_t e);
        logic [31:0] v;
        v = '0;
        case (e.kind)
            K_DATA: v = (e.dut == 0) ? rd_a[e.port*XLEN +: XLEN] : rd_b[e.port*XLEN +: XLEN];
            K_BUSY: v = {31'b0, (e.dut == 0) ? rb_a[e.port] : rb_b[e.port]};
            K_VEC:  v = (e.dut == 0) ? vec_a : vec_b;
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic check(exp_t e);
        logic [31:0] act;
        act = actual(e);
        checks++;
        if (act !== e.exp) begin
            failures++;
            $display("FAIL %s dut%0d port%0d: got 0x%08h want 0x%08h", e.name, e.dut, e.port, act, e.exp);
        end
    endtask

    // Monitor: outputs are combinational/registered and present every cycle,
    // so all expectations queued for the current cycle are checked mid-cycle.
    initial begin
        forever begin
            @(negedge clock);
            while (sb.size() > 0) check(sb.pop_front());
        end
    end

    task automatic push(string name, int dut, kind_t kind, int port, logic [31:0] exp);
        exp_t e;
        e.name = name; e.dut = dut; e.kind = kind; e.port = port; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        reg_wr_en = '0;
        rsv_en    = 1'b0;
    endtask

    task automatic wr(int k, int addr, logic [31:0] data);
        reg_wr_en[k]               = 1'b1;
        write_reg[k*AW +: AW]      = addr[AW-1:0];
        write_data[k*XLEN +: XLEN] = data;
    endtask

    task automatic rd(int j, int addr);
        read_reg[j*AW +: AW] = addr[AW-1:0];
    endtask

    task automatic rsv(int addr);
        rsv_en  = 1'b1;
        rsv_reg = addr[AW-1:0];
    endtask

    initial begin
        resetn = 1'b0; reg_wr_en = '0; write_reg = '0; write_data = '0;
        read_reg = '0; rsv_en = 1'b0; rsv_reg = '0;
        @(posedge clock);
        #1;

        // Write attempted during reset is dropped; bypass is suppressed too.
        wr(0, 5, 32'hDEADBEEF); rd(0, 5);
        push("rst_rd_bypass", 0, K_DATA, 0, 32'h0);
        push("rst_rd", 1, K_DATA, 0, 32'h0);
        push("rst_vec", 0, K_VEC, 0, 32'h0);
        push("rst_vec", 1, K_VEC, 0, 32'h0);
        step();
        resetn = 1'b1;
        rd(0, 5); rd(1, 5);
        push("x5_after_rst", 0, K_DATA, 0, 32'h0);
        push("x5_after_rst", 1, K_DATA, 1, 32'h0);
        step();

        for (int r = 0; r < 32; r++) begin
            rd(0, r); rd(1, 31 - r);
            push("rst_all_p0", 0, K_DATA, 0, 32'h0);
            push("rst_all_p1", 0, K_DATA, 1, 32'h0);
            push("rst_all_p0", 1, K_DATA, 0, 32'h0);
            push("rst_all_busy", 0, K_BUSY, 1, 32'h0);
            step();
        end

        // Register 0 is hardwired zero and cannot be reserved.
        wr(0, 0, 32'h12345678); rd(0, 0);
        push("x0_wr_same", 0, K_DATA, 0, 32'h0);
        step();
        rsv(0); rd(0, 0);
        push("x0_rd_next", 0, K_DATA, 0, 32'h0);
        push("x0_rd_next", 1, K_DATA, 0, 32'h0);
        step();
        push("x0_rsv_vec", 0, K_VEC, 0, 32'h0);
        push("x0_rsv_vec", 1, K_VEC, 0, 32'h0);
        step();

        // Same-cycle read of a written register: bypass vs stored value.
        wr(0, 7, 32'hA5A5A5A5); rd(0, 7);
        push("x7_same", 0, K_DATA, 0, 32'hA5A5A5A5);
        push("x7_same", 1, K_DATA, 0, 32'h0);
        step();
        rd(0, 7);
        push("x7_next", 0, K_DATA, 0, 32'hA5A5A5A5);
        push("x7_next", 1, K_DATA, 0, 32'hA5A5A5A5);
        step();

        // Dual write to x3: port 1 wins.
        wr(0, 3, 32'h11); wr(1, 3, 32'h22); rd(1, 3);
        push("x3_conf_same", 0, K_DATA, 1, 32'h22);
        push("x3_conf_same", 1, K_DATA, 1, 32'h0);
        step();
        rd(1, 3);
        push("x3_conf_next", 0, K_DATA, 1, 32'h22);
        push("x3_conf_next", 1, K_DATA, 1, 32'h11);
        step();

        // Two ports to distinct registers in one cycle.
        wr(0, 4, 32'h44); wr(1, 5, 32'h55);
        step();
        rd(0, 4); rd(1, 5);
        push("dual_x4", 0, K_DATA, 0, 32'h44);
        push("dual_x5", 0, K_DATA, 1, 32'h55);
        push("dual_x4", 1, K_DATA, 0, 32'h44);
        push("dual_x5", 1, K_DATA, 1, 32'h0);
        step();

        // Scoreboard on x9: set, set-beats-clear, then clear.
        rsv(9); rd(0, 9);
        push("x9_busy_same", 0, K_BUSY, 0, 32'h0);
        step();
        wr(0, 9, 32'h55); rsv(9); rd(0, 9);
        push("x9_busy_set", 0, K_BUSY, 0, 32'h1);
        push("x9_busy_set", 1, K_BUSY, 0, 32'h1);
        push("x9_vec_set", 0, K_VEC, 0, 32'h0000_0200);
        step();
        wr(0, 9, 32'h66); rd(0, 9);
        push("x9_busy_setwin", 0, K_BUSY, 0, 32'h1);
        push("x9_busy_setwin", 1, K_BUSY, 0, 32'h1);
        push("x9_rd_bypass", 0, K_DATA, 0, 32'h66);
        push("x9_rd_stored", 1, K_DATA, 0, 32'h55);
        step();
        rd(0, 9);
        push("x9_busy_clr", 0, K_BUSY, 0, 32'h0);
        push("x9_vec_clr", 0, K_VEC, 0, 32'h0);
        push("x9_vec_clr", 1, K_VEC, 0, 32'h0);
        push("x9_rd", 0, K_DATA, 0, 32'h66);
        push("x9_rd", 1, K_DATA, 0, 32'h66);
        step();

        // Write to a non-busy register leaves busy clear.
        wr(0, 10, 32'h10);
        step();
        rd(0, 10);
        push("x10_busy", 0, K_BUSY, 0, 32'h0);
        push("x10_rd", 0, K_DATA, 0, 32'h10);
        step();

        // Write port 1 clears busy; dut_b never sees port 1.
        rsv(12);
        step();
        wr(1, 12, 32'h12);
        step();
        rd(0, 12);
        push("x12_vec_p1clr", 0, K_VEC, 0, 32'h0);
        push("x12_vec_nop1", 1, K_VEC, 0, 32'h0000_1000);
        push("x12_rd", 0, K_DATA, 0, 32'h12);
        step();

        // Reset mid-operation: state clears at once, in-flight ops dropped.
        wr(0, 11, 32'hBB); rsv(13); rd(0, 7); rd(1, 11);
        resetn = 1'b0;
        #1;
        push("midrst_x7", 0, K_DATA, 0, 32'h0);
        push("midrst_x11", 0, K_DATA, 1, 32'h0);
        push("midrst_x7", 1, K_DATA, 0, 32'h0);
        push("midrst_vec", 0, K_VEC, 0, 32'h0);
        push("midrst_vec", 1, K_VEC, 0, 32'h0);
        step();
        resetn = 1'b1;
        rd(0, 11); rd(1, 7);
        push("postrst_x11", 0, K_DATA, 0, 32'h0);
        push("postrst_x7", 0, K_DATA, 1, 32'h0);
        push("postrst_x7", 1, K_DATA, 1, 32'h0);
        step();
        rd(0, 13);
        push("postrst_busy13", 0, K_BUSY, 0, 32'h0);
        push("postrst_vec", 0, K_VEC, 0, 32'h0);
        step();
        step();

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d entries left want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
